multi_servo_pwm: RTL and testbench
==================================

// Module: multi_servo_pwm
// PURPOSE
//  N-channel hobby-servo PWM generator; parametrised successor to the single-channel servo_pwm.
//  Per-channel angle targets are written over a simple write port; each output moves to its
//  target with an optional per-frame slew limit. Outputs are frame-synchronous and glitch-free.
//  Sits beside memory_manager in core_top; memory-mapped servo registers drive the write port.
// PARAMETERS
//  N_CH       4           number of servo channels (1..16)
//  ANGLE_W    8           width of angle values
//  MAX_ANGLE  180         largest legal angle; larger writes saturate to this value
//  CLK_HZ     50_000_000  clk frequency; TICKS_PER_US = CLK_HZ/1_000_000 (integer, >=1)
//  PERIOD_US  20000       frame period in microseconds
//  MIN_US     1000        pulse width at angle 0
//  MAX_US     2000        pulse width at MAX_ANGLE (MAX_US < PERIOD_US); SPAN_US = MAX_US-MIN_US
//  SLEW_STEP  0           max angle change per frame per channel; 0 = jump straight to target
// PORTS
//  clk        in   1              system clock
//  reset      in   1              asynchronous, active-low reset
//  wr_en      in   1              write strobe, one cycle per write
//  wr_ch      in   4              channel index for the write
//  wr_angle   in   ANGLE_W        target angle for the write
//  ch_en      in   N_CH           per-channel output enable
//  pwm        out  N_CH           servo pulse outputs
//  busy       out  N_CH           1 while the channel's current angle != its target
//  frame_stb  out  1              one-cycle pulse on the last clk cycle of every frame
// BEHAVIOUR
//  Reset (reset=0, acts immediately): pwm=0, busy=0, frame_stb=0. Every target=cur=MAX_ANGLE/2.
//    Prescaler and us counter cleared. Enable latch cleared. First frame starts on first clk after release.
//  Timebase: prescaler 0..TICKS_PER_US-1; us_cnt advances on prescaler wrap, 0..PERIOD_US-1, then wraps.
//    Frame length is exactly PERIOD_US*TICKS_PER_US cycles. frame_stb=1 iff prescaler and us_cnt both at max.
//  Write port: on a clk edge with wr_en=1 and wr_ch<N_CH:
//    target[wr_ch] <= min(wr_angle, MAX_ANGLE).
//    wr_ch>=N_CH is ignored with no state change. Writes do not alter the frame in progress.
//  Frame update, on the edge where frame_stb=1:
//    cur[ch] moves toward target[ch] by min(|diff|, SLEW_STEP); with SLEW_STEP=0 it copies target.
//    Uses the target held before that edge; a write on the same edge lands in target and applies one frame later.
//    pulse_us[ch] <= MIN_US + (new_cur*SPAN_US)/MAX_ANGLE, truncating; widths sized so no overflow.
//    en_lat[ch] <= ch_en[ch].
//  Output: in each frame, pwm[ch] is high for exactly pulse_us[ch]*TICKS_PER_US cycles, starting on
//    the frame's first cycle, and low for the rest. If en_lat[ch]=0 the channel stays low for the whole frame.
//    A ch_en change mid-frame never truncates or starts a pulse.
//  busy[ch] = (cur[ch] != target[ch]), registered. It updates on the cycle after a write or after a frame update.
//  The initial frame after reset gives every channel a pulse of MIN_US+SPAN_US*(MAX_ANGLE/2)/MAX_ANGLE us.
//    With en_lat cleared at reset, outputs stay low until the first frame_stb latches ch_en.
//  Channels are fully independent; an update on one never disturbs another's pulse.
// TESTING  (sim params: CLK_HZ=1_000_000, PERIOD_US=2500, MIN_US=1000, MAX_US=2000, MAX_ANGLE=180)
//  1 reset; release with ch_en=4'hF, no writes -> frame_stb every 2500 cycles.
//    Frame 0: pwm=0. From frame 1: every pwm high 1500 cycles, low 1000.
//  2 mid-frame write ch1=180 -> current frame ch1 still 1500; busy[1]=1 next cycle.
//    Following frame: ch1 2000 cycles, busy[1]=0; ch0/2/3 stay 1500.
//  3 write ch2=255 -> ch2 saturates, 2000-cycle pulse. Write wr_ch=7 -> no change on any channel.
//    Write on the frame_stb cycle -> takes effect one frame later.
//  4 SLEW_STEP=10, write ch0=0 from 90 -> successive pulses 1444,1388,1333,...,1055,1000 (9 frames).
//    busy[0] drops after the 9th update.
//  5 ch_en[2]=0 at frame boundary -> pwm[2] low whole frame.
//    Re-raise mid-frame -> no partial pulse; full pulse resumes after next frame_stb.
//  6 assert reset during a pulse -> all pwm=0 the same cycle. After release, timing restarts as in test 1.
//    Targets are back to 90.

Source files
------------

// File: rtl/multi_servo_pwm.sv
// N-channel hobby-servo PWM generator. Angle targets arrive over a strobe write port;
// each channel's pulse width follows its target once per frame, optionally slew-limited.
module multi_servo_pwm #(
    parameter int unsigned N_CH      = 4,
    parameter int unsigned ANGLE_W   = 8,
    parameter int unsigned MAX_ANGLE = 180,
    parameter int unsigned CLK_HZ    = 50_000_000,
    parameter int unsigned PERIOD_US = 20000,
    parameter int unsigned MIN_US    = 1000,
    parameter int unsigned MAX_US    = 2000,
    parameter int unsigned SLEW_STEP = 0
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               wr_en,
    input  logic [3:0]         wr_ch,
    input  logic [ANGLE_W-1:0] wr_angle,
    input  logic [N_CH-1:0]    ch_en,
    output logic [N_CH-1:0]    pwm,
    output logic [N_CH-1:0]    busy,
    output logic               frame_stb
);

    localparam int unsigned TICKS_PER_US = CLK_HZ / 1_000_000;
    localparam int unsigned SPAN_US      = MAX_US - MIN_US;
    localparam int unsigned PRE_W        = (TICKS_PER_US > 1) ? $clog2(TICKS_PER_US) : 1;
    localparam int unsigned US_W         = (PERIOD_US > 1) ? $clog2(PERIOD_US) : 1;
    localparam int unsigned SPAN_W       = (SPAN_US > 0) ? $clog2(SPAN_US + 1) : 1;
    localparam int unsigned PROD_W       = ANGLE_W + SPAN_W;

    localparam logic [PRE_W-1:0]   PRE_MAX    = PRE_W'(TICKS_PER_US - 1);
    localparam logic [US_W-1:0]    US_MAX     = US_W'(PERIOD_US - 1);
    localparam logic [ANGLE_W-1:0] ANGLE_MAX  = ANGLE_W'(MAX_ANGLE);
    localparam logic [ANGLE_W-1:0] ANGLE_HOME = ANGLE_W'(MAX_ANGLE / 2);
    localparam logic [ANGLE_W-1:0] STEP       = ANGLE_W'(SLEW_STEP);

    // Pulse width in microseconds for a given angle, truncating the linear map.
    function automatic logic [US_W-1:0] angle_to_us(input logic [ANGLE_W-1:0] angle);
        logic [PROD_W-1:0] prod;
        logic [PROD_W-1:0] quot;
        prod = PROD_W'(angle) * PROD_W'(SPAN_US);
        quot = prod / PROD_W'(MAX_ANGLE);
        return US_W'(MIN_US) + US_W'(quot);
    endfunction

    function automatic logic [ANGLE_W-1:0] slew_toward(input logic [ANGLE_W-1:0] cur,
                                                        input logic [ANGLE_W-1:0] tgt);
        logic [ANGLE_W-1:0] diff;
        if (SLEW_STEP == 0 || cur == tgt) begin
            return tgt;
        end
        if (tgt > cur) begin
            diff = tgt - cur;
            return (diff > STEP) ? cur + STEP : tgt;
        end
        diff = cur - tgt;
        return (diff > STEP) ? cur - STEP : tgt;
    endfunction

    localparam logic [US_W-1:0] PULSE_HOME = angle_to_us(ANGLE_HOME);

    logic [PRE_W-1:0]   pre_q, pre_next;
    logic [US_W-1:0]    us_q, us_next;
    logic               pre_wrap, us_wrap;
    logic [ANGLE_W-1:0] wr_sat;
    logic [ANGLE_W-1:0] target_q    [N_CH];
    logic [ANGLE_W-1:0] target_next [N_CH];
    logic [ANGLE_W-1:0] cur_q       [N_CH];
    logic [ANGLE_W-1:0] cur_next    [N_CH];
    logic [US_W-1:0]    pulse_q     [N_CH];
    logic [US_W-1:0]    pulse_next  [N_CH];
    logic [N_CH-1:0]    en_q, en_next;
    logic [N_CH-1:0]    pwm_next, busy_next;

    always_comb begin
        pre_wrap  = (pre_q == PRE_MAX);
        us_wrap   = (us_q == US_MAX);
        frame_stb = pre_wrap && us_wrap;
        pre_next  = pre_wrap ? '0 : pre_q + PRE_W'(1);
        us_next   = us_q;
        if (pre_wrap) begin
            us_next = us_wrap ? '0 : us_q + US_W'(1);
        end
    end

    // wr_en is a single-cycle strobe with no back-pressure: a write to a valid channel
    // lands on the edge it is sampled; an out-of-range channel index is dropped silently.
    always_comb begin
        wr_sat  = (wr_angle > ANGLE_MAX) ? ANGLE_MAX : wr_angle;
        en_next = en_q;
        for (int i = 0; i < int'(N_CH); i++) begin
            target_next[i] = target_q[i];
            cur_next[i]    = cur_q[i];
            pulse_next[i]  = pulse_q[i];
            if (wr_en && wr_ch == 4'(i)) begin
                target_next[i] = wr_sat;
            end
            // The frame update steps toward the target held before this edge.
            if (frame_stb) begin
                cur_next[i]   = slew_toward(cur_q[i], target_q[i]);
                pulse_next[i] = angle_to_us(cur_next[i]);
                en_next[i]    = ch_en[i];
            end
            busy_next[i] = (cur_next[i] != target_next[i]);
            // Registered so the pin reflects the cycle about to start, free of compare glitches.
            pwm_next[i]  = en_next[i] && (us_next < pulse_next[i]);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pre_q <= '0;
            us_q  <= '0;
            en_q  <= '0;
            pwm   <= '0;
            busy  <= '0;
            for (int i = 0; i < int'(N_CH); i++) begin
                target_q[i] <= ANGLE_HOME;
                cur_q[i]    <= ANGLE_HOME;
                pulse_q[i]  <= PULSE_HOME;
            end
        end else begin
            pre_q <= pre_next;
            us_q  <= us_next;
            en_q  <= en_next;
            pwm   <= pwm_next;
            busy  <= busy_next;
            for (int i = 0; i < int'(N_CH); i++) begin
                target_q[i] <= target_next[i];
                cur_q[i]    <= cur_next[i];
                pulse_q[i]  <= pulse_next[i];
            end
        end
    end

endmodule

// File: tb/tb_multi_servo_pwm.sv
// Bench for multi_servo_pwm: two instances (no slew and slew 10) share stimulus and are
// checked frame by frame against an arithmetic model of targets, angles and pulse widths.
module tb_multi_servo_pwm;

    localparam int NCH   = 4;
    localparam int FRAME = 2500;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       wr_en = 1'b0;
    logic [3:0] wr_ch = 4'd0;
    logic [7:0] wr_angle = 8'd0;
    logic [3:0] ch_en = 4'd0;
    logic [3:0] pwm_v  [2];
    logic [3:0] busy_v [2];
    logic       stb_v  [2];

    int n_cmp = 0;
    int n_err = 0;

    int   m_tgt   [2][NCH];
    int   m_cur   [2][NCH];
    int   m_pulse [2][NCH];
    bit   m_en    [2][NCH];
    int   hi_cnt  [2][NCH];
    bit   had_low [2][NCH];
    bit   glitch  [2][NCH];
    int   cyc     [2];
    logic [3:0] last_busy  [2];
    logic [3:0] last_mbusy [2];

    always #5 clk = ~clk;

    multi_servo_pwm #(
        .N_CH(4), .ANGLE_W(8), .MAX_ANGLE(180), .CLK_HZ(1_000_000),
        .PERIOD_US(2500), .MIN_US(1000), .MAX_US(2000), .SLEW_STEP(0)
    ) dut (
        .clk(clk), .reset(reset), .wr_en(wr_en), .wr_ch(wr_ch), .wr_angle(wr_angle),
        .ch_en(ch_en), .pwm(pwm_v[0]), .busy(busy_v[0]), .frame_stb(stb_v[0])
    );

    multi_servo_pwm #(
        .N_CH(4), .ANGLE_W(8), .MAX_ANGLE(180), .CLK_HZ(1_000_000),
        .PERIOD_US(2500), .MIN_US(1000), .MAX_US(2000), .SLEW_STEP(10)
    ) dut_slew (
        .clk(clk), .reset(reset), .wr_en(wr_en), .wr_ch(wr_ch), .wr_angle(wr_angle),
        .ch_en(ch_en), .pwm(pwm_v[1]), .busy(busy_v[1]), .frame_stb(stb_v[1])
    );

    task automatic check(input string tag, input int obs, input int exp);
        n_cmp++;
        if (obs != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic int us_of(input int angle);
        return 1000 + (angle * 1000) / 180;
    endfunction

    function automatic int step_of(input int d);
        return (d == 0) ? 0 : 10;
    endfunction

    function automatic logic [3:0] model_busy(input int d);
        logic [3:0] b;
        for (int ch = 0; ch < NCH; ch++) b[ch] = (m_cur[d][ch] != m_tgt[d][ch]);
        return b;
    endfunction

    task automatic model_write(input int ch, input int ang);
        if (ch < NCH) begin
            for (int d = 0; d < 2; d++) m_tgt[d][ch] = (ang > 180) ? 180 : ang;
        end
    endtask

    task automatic model_frame(input int d);
        int diff, mv;
        for (int ch = 0; ch < NCH; ch++) begin
            diff = m_tgt[d][ch] - m_cur[d][ch];
            if (step_of(d) == 0) mv = diff;
            else if (diff > 0) mv = (diff > step_of(d)) ? step_of(d) : diff;
            else mv = (-diff > step_of(d)) ? -step_of(d) : diff;
            m_cur[d][ch]   = m_cur[d][ch] + mv;
            m_pulse[d][ch] = us_of(m_cur[d][ch]);
            m_en[d][ch]    = ch_en[ch];
        end
    endtask

    // Monitor: measures each channel's high time per frame and compares at frame end.
    always @(negedge clk) begin
        if (!reset) begin
            for (int d = 0; d < 2; d++) begin
                cyc[d] = 0;
                last_busy[d] = 4'd0;
                last_mbusy[d] = 4'd0;
                for (int ch = 0; ch < NCH; ch++) begin
                    m_tgt[d][ch] = 90;
                    m_cur[d][ch] = 90;
                    m_pulse[d][ch] = us_of(90);
                    m_en[d][ch] = 1'b0;
                    hi_cnt[d][ch] = 0;
                    had_low[d][ch] = 1'b0;
                    glitch[d][ch] = 1'b0;
                end
            end
        end else begin
            for (int d = 0; d < 2; d++) begin
                logic [3:0] mb;
                cyc[d]++;
                mb = model_busy(d);
                if (busy_v[d] != last_busy[d] || mb != last_mbusy[d] || cyc[d] % 128 == 0)
                    check($sformatf("busy_d%0d", d), int'(busy_v[d]), int'(mb));
                last_busy[d] = busy_v[d];
                last_mbusy[d] = mb;
                for (int ch = 0; ch < NCH; ch++) begin
                    if (pwm_v[d][ch] === 1'b1) begin
                        hi_cnt[d][ch]++;
                        if (had_low[d][ch]) glitch[d][ch] = 1'b1;
                    end else begin
                        had_low[d][ch] = 1'b1;
                    end
                end
                if (stb_v[d] === 1'b1) begin
                    check($sformatf("frame_len_d%0d", d), cyc[d], FRAME);
                    cyc[d] = 0;
                    for (int ch = 0; ch < NCH; ch++) begin
                        check($sformatf("pulse_d%0d_ch%0d", d, ch), hi_cnt[d][ch],
                              m_en[d][ch] ? m_pulse[d][ch] : 0);
                        check($sformatf("shape_d%0d_ch%0d", d, ch), int'(glitch[d][ch]), 0);
                        hi_cnt[d][ch] = 0;
                        had_low[d][ch] = 1'b0;
                        glitch[d][ch] = 1'b0;
                    end
                    model_frame(d);
                end
            end
            if (stb_v[0] === 1'b1 || stb_v[1] === 1'b1)
                check("stb_align", int'(stb_v[1]), int'(stb_v[0]));
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_write(input int ch, input int ang);
        wr_en = 1'b1;
        wr_ch = 4'(ch);
        wr_angle = 8'(ang);
        tick(1);
        wr_en = 1'b0;
        model_write(ch, ang);
    endtask

    // Returns positioned inside the next frame_stb cycle.
    task automatic wait_frames(input int n);
        int k;
        repeat (n) begin
            tick(1);
            k = 0;
            while (stb_v[0] !== 1'b1 && k < 3 * FRAME) begin
                tick(1);
                k++;
            end
            check("stb_seen", int'(stb_v[0]), 1);
        end
    endtask

    initial begin
        tick(3);
        for (int d = 0; d < 2; d++) begin
            check($sformatf("rst_pwm_d%0d", d), int'(pwm_v[d]), 0);
            check($sformatf("rst_busy_d%0d", d), int'(busy_v[d]), 0);
            check($sformatf("rst_stb_d%0d", d), int'(stb_v[d]), 0);
        end
        ch_en = 4'hF;
        reset = 1'b1;
        wait_frames(3);

        tick(700);
        do_write(1, 180);
        check("busy_after_wr_d0", int'(busy_v[0][1]), 1);
        check("busy_after_wr_d1", int'(busy_v[1][1]), 1);
        wait_frames(2);

        tick(300);
        do_write(2, 255);
        tick(50);
        do_write(7, 33);
        wait_frames(1);
        do_write(3, 0);
        wait_frames(2);

        tick(100);
        do_write(0, 0);
        wait_frames(8);
        check("slew_busy_mid", int'(busy_v[1][0]), 1);
        wait_frames(2);
        check("slew_busy_done", int'(busy_v[1][0]), 0);

        wait_frames(1);
        ch_en = 4'b1011;
        tick(1000);
        ch_en = 4'hF;
        wait_frames(2);

        tick(500);
        reset = 1'b0;
        #1;
        for (int d = 0; d < 2; d++) begin
            check($sformatf("async_rst_pwm_d%0d", d), int'(pwm_v[d]), 0);
            check($sformatf("async_rst_busy_d%0d", d), int'(busy_v[d]), 0);
        end
        tick(3);
        reset = 1'b1;
        wait_frames(3);

        for (int it = 0; it < 25; it++) begin
            tick($urandom_range(20, 500));
            case ($urandom_range(0, 5))
                0, 1, 2: do_write($urandom_range(0, 7), $urandom_range(0, 255));
                3, 4:    ch_en = 4'($urandom_range(0, 15));
                default: begin
                    wait_frames(1);
                    do_write($urandom_range(0, 3), $urandom_range(0, 200));
                end
            endcase
        end
        wait_frames(3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
